galois_inv_sync: RTL
====================

// Module: galois_inv_sync
// PURPOSE
//   Computes the multiplicative inverse a^-1 mod PRIME_MODULUS. Together with galois_mult_barrett_sync it
//   provides field division: a/b = a * b^-1. Iterative binary extended Euclid, one step per clock, with
//   valid/ready handshakes on both sides. One operation in flight at a time.
// PARAMETERS
//   N_BITS         254     field element width
//   PRIME_MODULUS  254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001
//                          odd prime p, size N_BITS
// PORTS
//   clk        in   1       clock, all state on rising edge
//   rst        in   1       asynchronous reset, active-high
//   in_valid   in   1       num is valid
//   in_ready   out  1       block can accept an operand (IDLE state)
//   num        in   N_BITS  operand a; must satisfy a < p
//   out_valid  out  1       inverse/err_zero are valid
//   out_ready  in   1       consumer accepts result
//   inverse    out  N_BITS  a^-1 mod p, in [1, p-1]; 0 when err_zero
//   err_zero   out  1       operand was 0 (no inverse exists)
// BEHAVIOUR
//   Reset: state=IDLE, in_ready=1, out_valid=0, inverse=0, err_zero=0, all working registers cleared.
//   Registers: u, v (N_BITS); x1, x2 (N_BITS+1 for intermediate add/sub); state IDLE/RUN/DONE.
//   IDLE: in_valid & in_ready -> latch u=num, v=p, x1=1, x2=0.
//     If num==0: go DONE directly, inverse=0, err_zero=1 (result visible next cycle).
//     Else go RUN. in_ready=0 in RUN and DONE.
//   RUN: exactly one action per cycle, first matching rule wins:
//     1. u==1 -> inverse=x1, err_zero=0, go DONE.
//     2. v==1 -> inverse=x2, err_zero=0, go DONE.
//     3. u even -> u=u>>1; x1 = x1 even ? x1>>1 : (x1+p)>>1 (sum is N_BITS+1 bits, no loss).
//     4. v even -> v=v>>1; x2 likewise with p.
//     5. u>=v -> u=u-v; x1 = x1>=x2 ? x1-x2 : x1-x2+p.
//     6. else -> v=v-u; x2 = x2>=x1 ? x2-x1 : x2-x1+p.
//   Invariants: x1,x2 always in [0,p-1]; u,v never 0 for nonzero a<p since gcd(a,p)=1.
//   Latency: num==1 -> out_valid 2 cycles after accept. Worst case bounded by 4*N_BITS+2 cycles.
//     Rule: at most 2*N_BITS halvings total, each subtraction followed by a halving.
//   DONE: out_valid=1; inverse/err_zero held stable while out_ready=0.
//     out_valid & out_ready -> out_valid=0, go IDLE, in_ready=1 next cycle.
//     No same-cycle accept of a new operand in DONE.
//   in_valid while busy is ignored; the producer must hold num until in_ready.
//   num >= p: out of contract; the result is undefined but the FSM must still terminate.
//     Cap RUN at 4*N_BITS+2 steps, then go DONE with err_zero=1.
//   rst asserted mid-RUN or mid-DONE: immediate return to reset values; the pending result is discarded.
//   Outputs are registered, with no combinational path from in_valid/out_ready to any output.
// TESTING
//   a=1 -> inverse=1, err_zero=0, out_valid exactly 2 cycles after accept.
//   a=2 -> inverse=0x183227397098d014dc2822db40c0ac2e9419f4243cdcb848a1f0fac9f8000001 ((p+1)/2).
//   a=p-1 -> inverse=p-1; a=0 -> err_zero=1, inverse=0, out_valid 1 cycle after accept.
//   Backpressure: hold out_ready=0 for 20 cycles after out_valid.
//     -> inverse stable, in_ready=0, in_valid pulses ignored; then out_ready=1 -> IDLE.
//   Reset mid-op: assert rst 10 cycles into a=3 -> outputs at reset values immediately.
//     After release, a=3 completes correctly with inverse*3 mod p == 1.
//   Random: 10k random a in [1,p-1], checked against galois_mult_barrett_sync(a, inverse)==1.
//     Per-op cycle count <= 4*N_BITS+2; random in_valid/out_ready throttling.

Source files
------------

// File: rtl/galois_inv_sync.sv
// galois_inv_sync: modular inverse a^-1 mod p by iterative binary extended
// Euclid, one reduction step per clock. Single operation in flight, with
// valid/ready handshakes on the operand and result sides. Outputs are decoded
// from, or held in, registers only.
module galois_inv_sync #(
  parameter int N_BITS = 254,
  parameter logic [N_BITS-1:0] PRIME_MODULUS =
    254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] num,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_BITS-1:0] inverse,
  output logic              err_zero
);

  // Step cap keeps the FSM finite even for out-of-contract operands (num >= p).
  localparam int MAX_STEPS = 4 * N_BITS + 2;
  localparam int CNT_W     = $clog2(MAX_STEPS + 1);
  localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(MAX_STEPS - 1);
  localparam logic [N_BITS:0]   P_EXT     = {1'b0, PRIME_MODULUS};
  localparam logic [N_BITS-1:0] ONE_N     = N_BITS'(1);
  localparam logic [N_BITS:0]   ONE_X     = (N_BITS + 1)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [N_BITS-1:0] u_q, u_d;
  logic [N_BITS-1:0] v_q, v_d;
  logic [N_BITS:0]   x1_q, x1_d;
  logic [N_BITS:0]   x2_q, x2_d;
  logic [N_BITS-1:0] inverse_q, inverse_d;
  logic              err_zero_q, err_zero_d;
  logic [CNT_W-1:0]  step_q, step_d;

  logic              u_is_one, v_is_one, cap_hit, num_is_zero;
  logic [N_BITS:0]   x1_sum, x2_sum;
  logic [N_BITS:0]   x1_half, x2_half;
  logic [N_BITS:0]   x1_sub, x2_sub;

  // Candidate results for every RUN rule; the rule priority picks one below.
  always_comb begin
    u_is_one    = (u_q == ONE_N);
    v_is_one    = (v_q == ONE_N);
    cap_hit     = (step_q == LAST_STEP);
    num_is_zero = (num == '0);
    // x < p < 2^N_BITS, so x + p fits in N_BITS+1 bits and halving is exact.
    x1_sum  = x1_q + P_EXT;
    x2_sum  = x2_q + P_EXT;
    x1_half = x1_q[0] ? (x1_sum >> 1) : (x1_q >> 1);
    x2_half = x2_q[0] ? (x2_sum >> 1) : (x2_q >> 1);
    // Adding p before subtracting keeps the difference non-negative.
    x1_sub  = (x1_q >= x2_q) ? (x1_q - x2_q) : (x1_sum - x2_q);
    x2_sub  = (x2_q >= x1_q) ? (x2_q - x1_q) : (x2_sum - x1_q);
  end

  // State register plus datapath registers; async reset discards any pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      u_q        <= '0;
      v_q        <= '0;
      x1_q       <= '0;
      x2_q       <= '0;
      inverse_q  <= '0;
      err_zero_q <= 1'b0;
      step_q     <= '0;
    end else begin
      state_q    <= state_d;
      u_q        <= u_d;
      v_q        <= v_d;
      x1_q       <= x1_d;
      x2_q       <= x2_d;
      inverse_q  <= inverse_d;
      err_zero_q <= err_zero_d;
      step_q     <= step_d;
    end
  end

  // Next-state logic: zero operand skips RUN; DONE waits for the consumer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = num_is_zero ? DONE : RUN;
        end
      end
      RUN: begin
        if (u_is_one || v_is_one || cap_hit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath update: operand latch in IDLE, one Euclid rule per RUN cycle.
  always_comb begin
    u_d        = u_q;
    v_d        = v_q;
    x1_d       = x1_q;
    x2_d       = x2_q;
    inverse_d  = inverse_q;
    err_zero_d = err_zero_q;
    step_d     = step_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          u_d    = num;
          v_d    = PRIME_MODULUS;
          x1_d   = ONE_X;
          x2_d   = '0;
          step_d = '0;
          if (num_is_zero) begin
            inverse_d  = '0;
            err_zero_d = 1'b1;
          end
        end
      end
      RUN: begin
        step_d = step_q + 1'b1;
        if (u_is_one) begin
          inverse_d  = x1_q[N_BITS-1:0];
          err_zero_d = 1'b0;
        end else if (v_is_one) begin
          inverse_d  = x2_q[N_BITS-1:0];
          err_zero_d = 1'b0;
        end else if (cap_hit) begin
          // Only reachable for operands outside [0, p).
          inverse_d  = '0;
          err_zero_d = 1'b1;
        end else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          x1_d = x1_half;
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          x2_d = x2_half;
        end else if (u_q >= v_q) begin
          u_d  = u_q - v_q;
          x1_d = x1_sub;
        end else begin
          v_d  = v_q - u_q;
          x2_d = x2_sub;
        end
      end
      default: ;
    endcase
  end

  // Handshake outputs decode the state register only (no input-to-output path).
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    inverse   = inverse_q;
    err_zero  = err_zero_q;
  end

endmodule
